// File: rtl/pfb_channel_scheduler_if.sv
// Handshake bundle between the AXI-Stream input channels, the channel
// scheduler and the shared polyphase-filter MAC datapath.
interface pfb_channel_scheduler_if #(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 3,
    parameter int PHASE_W = 2
);
    logic [NUM_CH-1:0]  ch_tvalid;
    logic [NUM_CH-1:0]  ch_tready;
    logic               dp_ready;
    logic               grant_valid;
    logic [CH_W-1:0]    grant_ch;
    logic [PHASE_W-1:0] grant_phase;
    logic               grant_last;

    // Scheduler side: presents grants and per-channel accepts.
    modport master (
        input  ch_tvalid,
        input  dp_ready,
        output ch_tready,
        output grant_valid,
        output grant_ch,
        output grant_phase,
        output grant_last
    );

    // Environment side: channel requests and datapath readiness.
    modport slave (
        output ch_tvalid,
        output dp_ready,
        input  ch_tready,
        input  grant_valid,
        input  grant_ch,
        input  grant_phase,
        input  grant_last
    );
endinterface

// File: rtl/pfb_channel_scheduler.sv
// Round-robin scheduler sharing one polyphase-filter MAC datapath between
// NUM_CH input channels. Tracks a decimation phase per channel, tags the last
// phase of each decimation period and flags persistent datapath stalls.
module pfb_channel_scheduler #(
    parameter int NUM_CH       = 8,
    parameter int CH_W         = 3,
    parameter int DECIM        = 4,
    parameter int PHASE_W      = 2,
    parameter int BLOCK_THRESH = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear_phase,
    pfb_channel_scheduler_if.master bus,
    output logic [15:0]             stall_count,
    output logic                    block
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [15:0]        THRESH     = 16'(BLOCK_THRESH);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM - 1);
    localparam logic [CH_W-1:0]    LAST_CH    = CH_W'(NUM_CH - 1);

    state_t             state;
    logic               grant_valid_q;
    logic [CH_W-1:0]    grant_ch_q;
    logic [PHASE_W-1:0] grant_phase_q;
    logic               grant_last_q;
    logic [PHASE_W-1:0] phase     [NUM_CH];
    logic [PHASE_W-1:0] phase_nxt [NUM_CH];
    logic [CH_W-1:0]    rr_ptr;
    logic               clr_pend;
    logic [15:0]        run_cnt;
    logic [15:0]        run_nxt;
    logic               handshake;
    logic               stall;
    logic               issue;
    logic [CH_W-1:0]    arb_ptr;
    logic [CH_W:0]      arb_res;
    logic               arb_found;
    logic [CH_W-1:0]    arb_ch;
    logic [NUM_CH-1:0]  tready;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        return (ch == LAST_CH) ? '0 : ch + 1'b1;
    endfunction

    function automatic logic [PHASE_W-1:0] next_phase(input logic [PHASE_W-1:0] ph);
        return (ph == LAST_PHASE) ? '0 : ph + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] sat_inc_thresh(input logic [15:0] v);
        return (v >= THRESH) ? THRESH : v + 16'd1;
    endfunction

    // First requester at or after ptr (mod NUM_CH); MSB flags that one exists.
    // Scanning from the far end lets the nearest requester overwrite the result.
    function automatic logic [CH_W:0] arbitrate(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_CH;
            if (req[idx]) begin
                res = {1'b1, CH_W'(idx)};
            end
        end
        return res;
    endfunction

    assign handshake = grant_valid_q & bus.dp_ready & bus.ch_tvalid[grant_ch_q];
    assign stall     = grant_valid_q & ~bus.dp_ready;
    // On a handshake the pointer moves past the served channel this very cycle,
    // so a back-to-back grant is arbitrated from the updated position.
    assign arb_ptr   = handshake ? next_ch(grant_ch_q) : rr_ptr;
    assign arb_res   = arbitrate(bus.ch_tvalid, arb_ptr);
    assign arb_found = arb_res[CH_W];
    assign arb_ch    = arb_res[CH_W-1:0];
    assign issue     = enable & arb_found & ((state == IDLE) | handshake);
    assign run_nxt   = stall ? sat_inc_thresh(run_cnt) : 16'd0;

    // Next per-channel phases: clears apply at once when idle, but only at the
    // handshake while a grant is held so the presented phase never changes.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            phase_nxt[i] = phase[i];
            if (state == IDLE) begin
                if (clear_phase) begin
                    phase_nxt[i] = '0;
                end
            end else if (handshake) begin
                if (clear_phase | clr_pend) begin
                    phase_nxt[i] = '0;
                end else if (CH_W'(i) == grant_ch_q) begin
                    phase_nxt[i] = next_phase(phase[i]);
                end
            end
        end
    end

    // Only the granted channel is offered an accept, and only while the datapath is ready.
    always_comb begin
        tready = '0;
        if (grant_valid_q & bus.dp_ready) begin
            tready[grant_ch_q] = 1'b1;
        end
    end

    assign bus.ch_tready   = tready;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_ch    = grant_ch_q;
    assign bus.grant_phase = grant_phase_q;
    assign bus.grant_last  = grant_last_q;

    // Grant FSM: issues, holds and retires grants; owns phases, pointer and deferred clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            grant_valid_q <= 1'b0;
            grant_ch_q    <= '0;
            grant_phase_q <= '0;
            grant_last_q  <= 1'b0;
            rr_ptr        <= '0;
            clr_pend      <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                phase[i] <= phase_nxt[i];
            end
            case (state)
                IDLE: begin
                    if (issue) begin
                        state         <= GRANT;
                        grant_valid_q <= 1'b1;
                        grant_ch_q    <= arb_ch;
                        grant_phase_q <= phase_nxt[arb_ch];
                        grant_last_q  <= (phase_nxt[arb_ch] == LAST_PHASE);
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        rr_ptr   <= next_ch(grant_ch_q);
                        clr_pend <= 1'b0;
                        if (issue) begin
                            grant_ch_q    <= arb_ch;
                            grant_phase_q <= phase_nxt[arb_ch];
                            grant_last_q  <= (phase_nxt[arb_ch] == LAST_PHASE);
                        end else begin
                            state         <= IDLE;
                            grant_valid_q <= 1'b0;
                        end
                    end else if (clear_phase) begin
                        clr_pend <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    grant_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall accounting: lifetime saturating count plus a consecutive-run detector feeding block.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
            run_cnt     <= 16'd0;
            block       <= 1'b0;
        end else begin
            if (stall) begin
                stall_count <= sat_inc16(stall_count);
            end
            run_cnt <= run_nxt;
            block   <= (run_nxt == THRESH);
        end
    end

endmodule

// File: tb/tb_pfb_channel_scheduler.sv
// Testbench for pfb_channel_scheduler: hand-derived vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pfb_channel_scheduler;

    localparam int NUM_CH  = 8;
    localparam int CH_W    = 3;
    localparam int DECIM   = 4;
    localparam int PHASE_W = 2;
    localparam int THRESH  = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear_phase;
    logic [15:0] stall_count;
    logic        block;

    pfb_channel_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PHASE_W(PHASE_W)) bus ();

    pfb_channel_scheduler #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DECIM(DECIM),
        .PHASE_W(PHASE_W), .BLOCK_THRESH(THRESH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .clear_phase (clear_phase),
        .bus         (bus),
        .stall_count (stall_count),
        .block       (block)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    int m_phase [NUM_CH];
    int m_ptr;
    bit m_clrpend;
    bit m_gv;
    int m_gch;
    int m_gph;
    int m_total;
    int m_consec;

    typedef struct {
        bit          en;
        bit          clr;
        logic [7:0]  tv;
        bit          dr;
        bit          e_gv;
        int          e_gch;
        int          e_gph;
        bit          e_last;
        logic [7:0]  e_tr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) m_phase[i] = 0;
        m_ptr = 0; m_clrpend = 0; m_gv = 0; m_gch = 0; m_gph = 0;
        m_total = 0; m_consec = 0;
    endtask

    task automatic model_update(input bit en, input bit clr, input logic [7:0] tv, input bit dr);
        bit hs;
        bit was_free;
        hs = m_gv && dr && tv[m_gch];
        if (m_gv && !dr) begin
            m_total++;
            m_consec++;
        end else begin
            m_consec = 0;
        end
        was_free = !m_gv || hs;
        if (m_gv) begin
            if (hs) begin
                if (clr || m_clrpend) begin
                    for (int i = 0; i < NUM_CH; i++) m_phase[i] = 0;
                end else begin
                    m_phase[m_gch] = (m_phase[m_gch] + 1) % DECIM;
                end
                m_clrpend = 0;
                m_ptr = (m_gch + 1) % NUM_CH;
                m_gv = 0;
            end else if (clr) begin
                m_clrpend = 1;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_CH; i++) m_phase[i] = 0;
        end
        if (was_free && en) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                c = (m_ptr + k) % NUM_CH;
                if (!m_gv && tv[c]) begin
                    m_gv = 1; m_gch = c; m_gph = m_phase[c];
                end
            end
        end
    endtask

    // One clock cycle: drive at the falling edge, compare against the model, advance the model.
    task automatic tick(input bit en, input bit clr, input logic [7:0] tv, input bit dr);
        logic [7:0] e_tr;
        @(negedge clock);
        enable = en; clear_phase = clr; bus.ch_tvalid = tv; bus.dp_ready = dr;
        #1;
        e_tr = '0;
        if (m_gv && dr) e_tr[m_gch] = 1'b1;
        check("model_grant_valid", bus.grant_valid, m_gv);
        if (m_gv) begin
            check("model_grant_ch", bus.grant_ch, m_gch);
            check("model_grant_phase", bus.grant_phase, m_gph);
            check("model_grant_last", bus.grant_last, (m_gph == DECIM - 1));
        end
        check("model_ch_tready", bus.ch_tready, e_tr);
        check("model_stall_count", stall_count, (m_total > 65535) ? 65535 : m_total);
        check("model_block", block, (m_consec >= THRESH));
        model_update(en, clr, tv, dr);
    endtask

    task automatic check_grant(input string name, input int ch, input int ph);
        check({name, "_valid"}, bus.grant_valid, 1);
        check({name, "_ch"}, bus.grant_ch, ch);
        check({name, "_phase"}, bus.grant_phase, ph);
        check({name, "_last"}, bus.grant_last, (ph == DECIM - 1));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; enable = 1'b0; clear_phase = 1'b0;
        bus.ch_tvalid = '0; bus.dp_ready = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic add_vec(input bit en, input bit clr, input logic [7:0] tv, input bit dr,
                           input bit e_gv, input int e_gch, input int e_gph, input bit e_last,
                           input logic [7:0] e_tr);
        vec_t v;
        v.en = en; v.clr = clr; v.tv = tv; v.dr = dr;
        v.e_gv = e_gv; v.e_gch = e_gch; v.e_gph = e_gph; v.e_last = e_last; v.e_tr = e_tr;
        vq.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //      en clr tv     dr  gv ch ph last tready
        add_vec(1, 0, 8'h00, 1,  0, 0, 0, 0, 8'h00);
        add_vec(1, 0, 8'h20, 1,  0, 0, 0, 0, 8'h00);
        add_vec(1, 0, 8'h20, 1,  1, 5, 0, 0, 8'h20);
        add_vec(1, 0, 8'h20, 1,  1, 5, 1, 0, 8'h20);
        add_vec(1, 0, 8'h20, 0,  1, 5, 2, 0, 8'h00);
        add_vec(1, 0, 8'h20, 1,  1, 5, 2, 0, 8'h20);
        add_vec(1, 0, 8'h21, 1,  1, 5, 3, 1, 8'h20);
        add_vec(1, 0, 8'h21, 1,  1, 0, 0, 0, 8'h01);
        add_vec(1, 0, 8'h00, 1,  1, 5, 0, 0, 8'h20);
        add_vec(1, 0, 8'h00, 1,  1, 5, 0, 0, 8'h20);
        add_vec(0, 0, 8'h20, 1,  1, 5, 0, 0, 8'h20);
        add_vec(0, 0, 8'h20, 1,  0, 0, 0, 0, 8'h00);
        add_vec(1, 0, 8'h20, 1,  0, 0, 0, 0, 8'h00);
        add_vec(1, 0, 8'h00, 0,  1, 5, 1, 0, 8'h00);

        // Reset state.
        reset = 1'b1; enable = 1'b0; clear_phase = 1'b0;
        bus.ch_tvalid = '0; bus.dp_ready = 1'b0;
        model_reset();
        #2;
        check("rst_grant_valid", bus.grant_valid, 0);
        check("rst_grant_ch", bus.grant_ch, 0);
        check("rst_grant_phase", bus.grant_phase, 0);
        check("rst_grant_last", bus.grant_last, 0);
        check("rst_stall_count", stall_count, 0);
        check("rst_block", block, 0);
        check("rst_ch_tready", bus.ch_tready, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Vector table.
        for (int i = 0; i < vq.size(); i++) begin
            tick(vq[i].en, vq[i].clr, vq[i].tv, vq[i].dr);
            check($sformatf("vec%0d_valid", i), bus.grant_valid, vq[i].e_gv);
            if (vq[i].e_gv) begin
                check($sformatf("vec%0d_ch", i), bus.grant_ch, vq[i].e_gch);
                check($sformatf("vec%0d_phase", i), bus.grant_phase, vq[i].e_gph);
                check($sformatf("vec%0d_last", i), bus.grant_last, vq[i].e_last);
            end
            check($sformatf("vec%0d_tready", i), bus.ch_tready, vq[i].e_tr);
        end

        // All channels valid: back-to-back round robin with phases 0..3.
        do_reset();
        tick(1, 0, 8'hFF, 1);
        check("rr_first_idle", bus.grant_valid, 0);
        for (int j = 0; j < 32; j++) begin
            tick(1, 0, 8'hFF, 1);
            check_grant("rr", j % NUM_CH, (j / NUM_CH) % DECIM);
        end

        // Sustained stall: block from the 65th stall cycle, drops after dp_ready returns.
        do_reset();
        tick(1, 0, 8'h04, 0);
        for (int s = 1; s <= 70; s++) begin
            tick(1, 0, 8'h04, 0);
            check("stall_block", block, (s >= 65));
        end
        tick(1, 0, 8'h04, 1);
        check("stall_count70", stall_count, 70);
        check("stall_block_hs", block, 1);
        tick(1, 0, 8'h00, 1);
        check("stall_block_clear", block, 0);
        check("stall_count_hold", stall_count, 70);

        // Deferred clear_phase while a phase-2 grant is held.
        do_reset();
        tick(1, 0, 8'h18, 1);
        tick(1, 0, 8'h18, 1); check_grant("clr_a", 3, 0);
        tick(1, 0, 8'h18, 1); check_grant("clr_b", 4, 0);
        tick(1, 0, 8'h18, 1); check_grant("clr_c", 3, 1);
        tick(1, 0, 8'h18, 1); check_grant("clr_d", 4, 1);
        tick(1, 0, 8'h18, 0); check_grant("clr_e", 3, 2);
        tick(1, 1, 8'h18, 0); check_grant("clr_held", 3, 2);
        tick(1, 0, 8'h18, 1); check_grant("clr_hs", 3, 2);
        tick(1, 0, 8'h18, 1); check_grant("clr_next", 4, 0);
        tick(1, 0, 8'h18, 1); check_grant("clr_next2", 3, 0);

        // Asynchronous reset in the middle of a held grant.
        do_reset();
        tick(1, 0, 8'h40, 1);
        tick(1, 0, 8'h40, 1); check_grant("arst_a", 6, 0);
        tick(1, 0, 8'h40, 1); check_grant("arst_b", 6, 1);
        tick(1, 0, 8'h40, 1); check_grant("arst_c", 6, 2);
        #2;
        reset = 1'b1;
        #1;
        check("arst_grant_valid", bus.grant_valid, 0);
        check("arst_ch_tready", bus.ch_tready, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0; enable = 1'b0;
        tick(1, 0, 8'h44, 1);
        check("arst_idle", bus.grant_valid, 0);
        tick(1, 0, 8'h44, 1); check_grant("arst_low", 2, 0);
        tick(1, 0, 8'h44, 1); check_grant("arst_ph0", 6, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit         en;
            bit         clr;
            bit         dr;
            logic [7:0] tv;
            en  = ($urandom % 8) != 0;
            clr = ($urandom % 16) == 0;
            tv  = ($urandom % 2) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            dr  = ($urandom % 4) != 0;
            if ((n % 500) >= 300 && (n % 500) < 380) dr = 1'b0;
            tick(en, clr, tv, dr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
